// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default bus widths, memory arbiter states and
// requester identifiers.
package cpu_pkg;

   localparam int CPU_ADDR_W = 8;
   localparam int CPU_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitrations the fetch port has lost.
module arb_starve_ctr #(
   parameter  int MAX = 4,
   localparam int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   assign sat = (cnt == W'(MAX));

   // NOTE: registers take non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port
// memory, one outstanding access at a time, with a fetch starvation bound.
module cpu_mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = CPU_ADDR_W,
   parameter int DATA_W     = CPU_DATA_W,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_RVALID,
   output logic [DATA_W-1:0] IF_RDATA,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [ADDR_W-1:0] DM_ADDR,
   input  logic [DATA_W-1:0] DM_WDATA,
   output logic              DM_GNT,
   output logic              DM_RVALID,
   output logic [DATA_W-1:0] DM_RDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   arb_state_e        state;
   logic              winner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [LAT_W-1:0]  lat_cnt;
   logic [SC_W-1:0]   starve_cnt;
   logic              starve_sat;

   logic arb_en;
   logic grant;
   logic grant_dm;

   // NOTE: every always_comb output gets a value on every path, otherwise
   // synthesis infers a latch to hold it.
   always_comb begin
      arb_en   = (state == ST_IDLE) || (state == ST_RESP);
      grant    = arb_en && (IF_REQ || DM_REQ);
      grant_dm = DM_REQ && !(IF_REQ && starve_sat);
   end

   arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
      .clk   (CLK),
      .rst_n (RESET),
      .inc   (grant && grant_dm && IF_REQ),
      .clr   (grant && !grant_dm),
      .cnt   (starve_cnt),
      .sat   (starve_sat)
   );

   // NOTE: the datapath registers are reset too, because they drive the
   // memory and read-data outputs directly and those must read 0 in reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= ST_IDLE;
         winner_q   <= REQ_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_RESP: state <= grant ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
               if (we_q) begin
                  state <= ST_IDLE;
               end else begin
                  state   <= ST_WAIT;
                  lat_cnt <= LAT_W'(MEM_LAT - 1);
               end
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= ST_RESP;
                  if (winner_q == REQ_DM) dm_rdata_q <= MEM_RDATA;
                  else                    if_rdata_q <= MEM_RDATA;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Write data only moves on DM grants so MEM_WDATA holds across fetches.
         if (grant) begin
            winner_q <= grant_dm ? REQ_DM : REQ_IF;
            we_q     <= grant_dm && DM_WE;
            addr_q   <= grant_dm ? DM_ADDR : IF_ADDR;
            if (grant_dm) wdata_q <= DM_WDATA;
         end
      end
   end

   assign IF_GNT    = (state == ST_ISSUE) && (winner_q == REQ_IF);
   assign DM_GNT    = (state == ST_ISSUE) && (winner_q == REQ_DM);
   assign IF_RVALID = (state == ST_RESP)  && (winner_q == REQ_IF);
   assign DM_RVALID = (state == ST_RESP)  && (winner_q == REQ_DM);
   assign IF_RDATA  = if_rdata_q;
   assign DM_RDATA  = dm_rdata_q;
   assign MEM_EN    = (state == ST_ISSUE);
   assign MEM_WE    = (state == ST_ISSUE) && we_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: one MEM_LAT=1 instance with a memory
// model, one MEM_LAT=3 instance used for the reset-during-WAIT case.
module tb_cpu_mem_arbiter;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1_n, rst3_n;
   logic        if_req, dm_req, dm_we;
   logic [7:0]  if_addr, dm_addr;
   logic [15:0] dm_wdata;

   logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, mem_we1, busy1;
   logic [15:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
   logic [7:0]  mem_addr1;

   logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, mem_we3, busy3;
   logic [15:0] if_rdata3, dm_rdata3, mem_wdata3;
   logic [15:0] mem_rdata3 = 16'hBEEF;
   logic [7:0]  mem_addr3;

   logic [15:0] mem [256];

   int vectors     = 0;
   int miscompares = 0;

   cpu_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .CLK(clk), .RESET(rst1_n),
      .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt1),
      .IF_RVALID(if_rvalid1), .IF_RDATA(if_rdata1),
      .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata),
      .DM_GNT(dm_gnt1), .DM_RVALID(dm_rvalid1), .DM_RDATA(dm_rdata1),
      .MEM_EN(mem_en1), .MEM_WE(mem_we1), .MEM_ADDR(mem_addr1),
      .MEM_WDATA(mem_wdata1), .MEM_RDATA(mem_rdata1), .BUSY(busy1)
   );

   cpu_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .CLK(clk), .RESET(rst3_n),
      .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt3),
      .IF_RVALID(if_rvalid3), .IF_RDATA(if_rdata3),
      .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata),
      .DM_GNT(dm_gnt3), .DM_RVALID(dm_rvalid3), .DM_RDATA(dm_rdata3),
      .MEM_EN(mem_en3), .MEM_WE(mem_we3), .MEM_ADDR(mem_addr3),
      .MEM_WDATA(mem_wdata3), .MEM_RDATA(mem_rdata3), .BUSY(busy3)
   );

   // Single-port memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en1) begin
         if (mem_we1) mem[mem_addr1] <= mem_wdata1;
         else         mem_rdata1 <= mem[mem_addr1];
      end
   end

   logic [62:0] outs1, outs3;
   assign outs1 = {if_gnt1, if_rvalid1, if_rdata1, dm_gnt1, dm_rvalid1, dm_rdata1,
                   mem_en1, mem_we1, mem_addr1, mem_wdata1, busy1};
   assign outs3 = {if_gnt3, if_rvalid3, if_rdata3, dm_gnt3, dm_rvalid3, dm_rdata3,
                   mem_en3, mem_we3, mem_addr3, mem_wdata3, busy3};

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dm_grants;
      int rv_seen;
      int busy_seen;
      logic if_won;

      rst1_n = 1'b0; rst3_n = 1'b0;
      if_req = 1'b1; if_addr = 8'h05;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 8'h00; dm_wdata = 16'h0000;
      mem_rdata1 = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h05] = 16'hA1B2;
      mem[8'h06] = 16'h1234;
      mem[8'h07] = 16'h0777;
      mem[8'h20] = 16'h5A5A;

      // Reset held with IF_REQ high
      tick(); tick();
      check("reset_outs", 64'(outs1), 64'd0);
      check("reset_busy", 64'(busy1), 64'd0);
      rst1_n = 1'b1;
      check("no_gnt_before_sample", 64'(if_gnt1), 64'd0);
      tick();
      check("first_if_gnt", 64'(if_gnt1), 64'd1);
      check("fetch_mem_en", 64'(mem_en1), 64'd1);
      check("fetch_mem_addr", 64'(mem_addr1), 64'h05);
      check("fetch_mem_we", 64'(mem_we1), 64'd0);
      if_req = 1'b0;
      tick();
      check("fetch_wait_rvalid", 64'(if_rvalid1), 64'd0);
      check("fetch_wait_busy", 64'(busy1), 64'd1);
      tick();
      check("fetch_rvalid", 64'(if_rvalid1), 64'd1);
      check("fetch_rdata", 64'(if_rdata1), 64'hA1B2);
      tick();
      check("fetch_rvalid_pulse", 64'(if_rvalid1), 64'd0);
      check("fetch_idle_busy", 64'(busy1), 64'd0);
      check("fetch_rdata_hold", 64'(if_rdata1), 64'hA1B2);

      // Collision: DM read wins, IF granted from RESP
      if_req = 1'b1; if_addr = 8'h06;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
      tick();
      check("coll_dm_gnt", 64'({dm_gnt1, if_gnt1}), 64'b10);
      check("coll_dm_addr", 64'(mem_addr1), 64'h20);
      check("coll_starve_inc", 64'(dut1.starve_cnt), 64'd1);
      dm_req = 1'b0;
      tick();
      check("coll_wait_gnt", 64'({dm_gnt1, if_gnt1, dm_rvalid1}), 64'b000);
      tick();
      check("coll_dm_rvalid", 64'(dm_rvalid1), 64'd1);
      check("coll_dm_rdata", 64'(dm_rdata1), 64'h5A5A);
      tick();
      check("coll_if_gnt_from_resp", 64'(if_gnt1), 64'd1);
      check("coll_if_addr", 64'(mem_addr1), 64'h06);
      check("coll_starve_clr", 64'(dut1.starve_cnt), 64'd0);
      if_req = 1'b0;
      tick(); tick();
      check("coll_if_rvalid", 64'({if_rvalid1, dm_rvalid1}), 64'b10);
      check("coll_if_rdata", 64'(if_rdata1), 64'h1234);
      check("coll_dm_rdata_hold", 64'(dm_rdata1), 64'h5A5A);
      tick();

      // DM write: single strobe, no response
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 16'h00FF;
      tick();
      check("wr_gnt", 64'(dm_gnt1), 64'd1);
      check("wr_en_we", 64'({mem_en1, mem_we1}), 64'b11);
      check("wr_wdata", 64'(mem_wdata1), 64'h00FF);
      check("wr_addr", 64'(mem_addr1), 64'h10);
      dm_req = 1'b0;
      tick();
      check("wr_busy_after", 64'(busy1), 64'd0);
      check("wr_no_rvalid", 64'(dm_rvalid1), 64'd0);
      check("wr_we_low", 64'({mem_en1, mem_we1}), 64'b00);
      check("wr_wdata_hold", 64'(mem_wdata1), 64'h00FF);

      // Starvation bound: DM writes held, IF held
      if_req = 1'b1; if_addr = 8'h07;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h30; dm_wdata = 16'h1111;
      dm_grants = 0;
      if_won = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dm_gnt1) dm_grants++;
         if (if_gnt1) begin
            if_won = 1'b1;
            break;
         end
      end
      check("starve_if_won", 64'(if_won), 64'd1);
      check("starve_dm_grants", 64'(dm_grants), 64'd4);
      check("starve_cnt_clr", 64'(dut1.starve_cnt), 64'd0);
      check("starve_if_addr", 64'(mem_addr1), 64'h07);
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick(); tick();
      check("starve_if_rdata", 64'({if_rvalid1, if_rdata1}), {47'd0, 1'b1, 16'h0777});
      tick();

      // Reset during the 2nd WAIT cycle with MEM_LAT = 3
      check("lat3_reset_outs", 64'(outs3), 64'd0);
      rst3_n = 1'b1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
      tick();
      check("lat3_dm_gnt", 64'(dm_gnt3), 64'd1);
      dm_req = 1'b0;
      tick(); tick();
      check("lat3_wait2_busy", 64'(busy3), 64'd1);
      rst3_n = 1'b0;
      #1;
      check("lat3_async_clear", 64'(outs3), 64'd0);
      #2;
      rst3_n = 1'b1;
      rv_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if_rvalid3 || dm_rvalid3) rv_seen++;
         if (busy3) busy_seen++;
      end
      check("lat3_no_rvalid", 64'(rv_seen), 64'd0);
      check("lat3_stays_idle", 64'(busy_seen), 64'd0);
      check("lat3_state_idle", 64'(dut3.state), 64'(ST_IDLE));
      check("lat3_outs_zero", 64'(outs3), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
